// File: rtl/dw_mac_seq_pkg.sv
// Shared types and constants for the dw_mac_seq dot-product sequencer.
package dw_mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Saturation limits as 64-bit patterns; callers truncate to the accumulator width.
  function automatic logic [63:0] sat_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smin(input int w);
    return ~64'd0 << (w - 1);
  endfunction

  function automatic logic [63:0] sat_umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/dw_mac_seq_dp.sv
// Datapath for dw_mac_seq: operand extension, product register and accumulator.
// MAC_SEQ_SAT_EN selects saturating accumulation with a sticky ovf flag; otherwise the sum wraps.
module dw_mac_seq_dp
  import dw_mac_seq_pkg::*;
#(
  parameter int A_WIDTH   = 6,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] init,
  input  logic                 tc,
  input  logic                 take,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 prod_v,
  output logic [OUT_WIDTH-1:0] acc,
  output logic                 ovf
);

  logic [OUT_WIDTH-1:0] a_ext, b_ext, prod_q, acc_d;
  logic                 clamp;

  assign a_ext = tc ? {{(OUT_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a} : {{(OUT_WIDTH-A_WIDTH){1'b0}}, a};
  assign b_ext = tc ? {{(OUT_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b} : {{(OUT_WIDTH-B_WIDTH){1'b0}}, b};

`ifdef MAC_SEQ_SAT_EN
  localparam logic [OUT_WIDTH-1:0] SMAX = OUT_WIDTH'(sat_smax(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] SMIN = OUT_WIDTH'(sat_smin(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] UMAX = OUT_WIDTH'(sat_umax(OUT_WIDTH));

  logic [OUT_WIDTH:0] sum_u, sum_s;

  // One guard bit: carry-out for unsigned, sign disagreement for signed.
  assign sum_u = {1'b0, acc} + {1'b0, prod_q};
  assign sum_s = {acc[OUT_WIDTH-1], acc} + {prod_q[OUT_WIDTH-1], prod_q};

  always_comb begin
    acc_d = sum_u[OUT_WIDTH-1:0];
    clamp = 1'b0;
    if (tc) begin
      if (sum_s[OUT_WIDTH] != sum_s[OUT_WIDTH-1]) begin
        clamp = 1'b1;
        acc_d = sum_s[OUT_WIDTH] ? SMIN : SMAX;
      end
    end else if (sum_u[OUT_WIDTH]) begin
      clamp = 1'b1;
      acc_d = UMAX;
    end
  end
`else
  assign acc_d = acc + prod_q;
  assign clamp = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      prod_v <= take;
      if (take) prod_q <= a_ext * b_ext;
      if (load) begin
        acc <= init;
        ovf <= 1'b0;
      end else if (prod_v) begin
        acc <= acc_d;
        if (clamp) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dw_mac_seq.sv
// dw_mac_seq: job sequencer feeding a shared MAC datapath (acc = init + sum a[i]*b[i]).
// Build option MAC_SEQ_SAT_EN enables saturating accumulation inside dw_mac_seq_dp.
module dw_mac_seq
  import dw_mac_seq_pkg::*;
#(
  parameter int A_WIDTH   = 6,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 18,
  parameter int MAX_LEN   = 16,
  localparam int LEN_W    = len_width(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [OUT_WIDTH-1:0] init,
  input  logic                 tc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_acc,
  output logic                 busy,
  output logic                 ovf
);

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_c, len_q, cnt_q;
  logic                 tc_q, load, take, prod_v;
  logic [OUT_WIDTH-1:0] acc, out_acc_q;

  assign len_c = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign take  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      tc_q      <= 1'b0;
      out_acc_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        len_q <= len_c;
        tc_q  <= tc;
        cnt_q <= '0;
      end else if (take) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (state_q == DONE) out_acc_q <= acc;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len_c != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        in_ready = (cnt_q < len_q);
        if (in_valid && in_ready && ((cnt_q + LEN_W'(1)) == len_q)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  // acc is quiet in DONE; the shadow copy keeps the result visible after the next job reloads acc.
  assign out_acc = (state_q == DONE) ? acc : out_acc_q;

  dw_mac_seq_dp #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .init  (init),
    .tc    (tc_q),
    .take  (take),
    .a     (in_a),
    .b     (in_b),
    .prod_v(prod_v),
    .acc   (acc),
    .ovf   (ovf)
  );

endmodule

// File: tb/tb_dw_mac_seq.sv
// Randomized self-checking bench for dw_mac_seq against an arithmetic dot-product model.
module tb_dw_mac_seq;

  localparam int AW = 6;
  localparam int BW = 8;
  localparam int OW = 18;
  localparam int ML = 16;
  localparam int LW = 5;
`ifdef MAC_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, tc, in_valid, out_ready;
  logic [LW-1:0] len;
  logic [OW-1:0] init;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_ready, out_valid, busy, ovf;
  logic [OW-1:0] out_acc;

  int vectors = 0;
  int errors  = 0;

  logic [OW-1:0] exp_acc;
  logic          exp_ovf;
  logic [AW-1:0] pa [ML];
  logic [BW-1:0] pb [ML];

  always #5 clk = ~clk;

  dw_mac_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .init     (init),
    .tc       (tc),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .busy     (busy),
    .ovf      (ovf)
  );

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction

  // Exact dot product over pa/pb, then clamp per step (saturating build) or reduce mod 2^OW.
  function automatic longint model(input bit t, input longint iv, input int n, output bit ov);
    longint m, acc, lo, hi, term;
    m  = longint'(1) << OW;
    ov = 1'b0;
    if (t) begin
      acc = sx(iv, OW); lo = -(m / 2); hi = m / 2 - 1;
    end else begin
      acc = iv; lo = 0; hi = m - 1;
    end
    for (int i = 0; i < n; i++) begin
      term = t ? sx(longint'(pa[i]), AW) * sx(longint'(pb[i]), BW)
               : longint'(pa[i]) * longint'(pb[i]);
      acc += term;
      if (SAT) begin
        if (acc > hi) begin acc = hi; ov = 1'b1; end
        else if (acc < lo) begin acc = lo; ov = 1'b1; end
      end
    end
    return acc & (m - 1);
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Continuous compare: a presented or retained result must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid || !busy) begin
        check("out_acc", out_acc, exp_acc);
        check("ovf", ovf, exp_ovf);
      end
      if (!busy) check("in_ready_idle", in_ready, 0);
    end
  end

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      pa[i] = AW'($urandom);
      pb[i] = BW'($urandom);
    end
  endtask

  task automatic run_job(input bit t, input logic [OW-1:0] iv, input int nraw,
                         input int gap_pct, input int hold, input string tag);
    int     n, idx, cyc;
    bit     ov;
    longint e;
    n = (nraw > ML) ? ML : nraw;
    e = model(t, longint'(iv), n, ov);
    start = 1'b1; len = LW'(nraw); init = iv; tc = t;
    exp_acc = OW'(e); exp_ovf = ov;
    tick();
    start = 1'b0; tc = 1'($urandom); len = LW'($urandom); init = OW'($urandom);
    if (n > 0) begin
      idx = 0; cyc = 0;
      while (idx < n && cyc < 400) begin
        check({tag, "_in_ready_run"}, in_ready, 1);
        in_valid = ($urandom_range(99) >= gap_pct);
        in_a = pa[idx]; in_b = pb[idx];
        if (in_valid) idx++;
        tick();
        cyc++;
        tc = 1'($urandom);
      end
      in_valid = 1'b0; in_a = AW'($urandom); in_b = BW'($urandom);
      if (idx < n) check({tag, "_pairs_accepted_timeout"}, idx, n);
      check({tag, "_drain_in_ready"}, in_ready, 0);
      check({tag, "_drain_out_valid"}, out_valid, 0);
      tick();
    end else begin
      check({tag, "_len0_in_ready"}, in_ready, 0);
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_busy_done"}, busy, 1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = 1'b1; init = ~iv; len = LW'($urandom);
      tick();
      check({tag, "_out_valid_held"}, out_valid, 1);
    end
    start = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e;
    bit     ov;
    rst = 1'b1; start = 1'b0; len = '0; init = '0; tc = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    exp_acc = '0; exp_ovf = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_ovf", ovf, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    pa[0] = 6'd3;  pb[0] = 8'd4;
    pa[1] = 6'd10; pb[1] = 8'd2;
    pa[2] = 6'd63; pb[2] = 8'd255;
    e = model(1'b0, 5, 3, ov);
    check("model_unsigned", e, 16102);
    run_job(1'b0, 18'd5, 3, 0, 0, "tp_unsigned");

    pa[0] = 6'h3F; pb[0] = 8'h02;
    pa[1] = 6'h20; pb[1] = 8'h80;
    e = model(1'b1, 0, 2, ov);
    check("model_signed", e, 4094);
    run_job(1'b1, 18'd0, 2, 0, 0, "tp_signed");

    e = model(1'b0, 18'h1ABCD, 0, ov);
    check("model_len0", e, 18'h1ABCD);
    run_job(1'b0, 18'h1ABCD, 0, 0, 0, "tp_len0");

    fill_random(4);
    run_job(1'b0, OW'($urandom), 4, 0, 5, "tp_backpressure");

    pa[0] = 6'd3;  pb[0] = 8'd4;
    pa[1] = 6'd10; pb[1] = 8'd2;
    pa[2] = 6'd63; pb[2] = 8'd255;
    run_job(1'b0, 18'd5, 3, 60, 0, "tp_gaps");

    fill_random(4);
    start = 1'b1; len = 5'd4; init = 18'd7; tc = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    in_a = pa[0]; in_b = pb[0]; tick();
    in_a = pa[1]; in_b = pb[1]; tick();
    in_valid = 1'b0;
    rst = 1'b1; exp_acc = '0; exp_ovf = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_acc", out_acc, 0);
    check("abort_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    tick();
    pa[0] = 6'd2; pb[0] = 8'd3;
    e = model(1'b0, 0, 1, ov);
    check("model_after_abort", e, 6);
    run_job(1'b0, 18'd0, 1, 0, 0, "tp_after_abort");

    pa[0] = 6'd1; pb[0] = 8'd1;
    e = model(1'b0, 18'h3FFFF, 1, ov);
`ifdef MAC_SEQ_SAT_EN
    check("model_sat_acc", e, 18'h3FFFF);
    check("model_sat_ovf", ov, 1);
`else
    check("model_wrap_acc", e, 0);
    check("model_wrap_ovf", ov, 0);
`endif
    run_job(1'b0, 18'h3FFFF, 1, 0, 0, "tp_sat");

    fill_random(ML);
    run_job(1'b1, OW'($urandom), 25, 20, 1, "tp_len_clamp");

    for (int j = 0; j < 40; j++) begin
      int nraw;
      nraw = $urandom_range(20);
      fill_random(ML);
      run_job(1'($urandom), OW'($urandom), nraw, $urandom_range(50), $urandom_range(3), "rnd");
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
